switch_cfg_regs: RTL and testbench

// - DUT-side responder for the switch memory/configuration interface; answers the memory-interface master.
// - Holds per-port destination addresses, a global enable and an error counter.
// - Exports the configuration to the switch datapath.
// - One access per mem_sel_en assertion: capture, execute, single-cycle mem_ack, then wait for release.

---
 rtl/switch_cfg_pkg.sv | 12 +
 rtl/switch_cfg_regs_bank.sv | 92 +++++++++
 rtl/switch_cfg_regs.sv | 87 ++++++++
 tb/tb_switch_cfg_regs.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/switch_cfg_pkg.sv
// Shared types and register map for the switch configuration responder.
package switch_cfg_pkg;

  typedef enum logic [1:0] {IDLE, EXEC, WAIT_REL} cfg_state_t;

  localparam logic [7:0] CFG_PORT_BASE = 8'h00;
  localparam logic [7:0] CFG_CTRL_ADDR = 8'h10;
  localparam logic [7:0] CFG_LOCK_ADDR = 8'h11;
  localparam logic [7:0] CFG_ERR_ADDR  = 8'h20;
  localparam logic [7:0] CFG_LOCK_KEY  = 8'hA5;

endpackage

// File: rtl/switch_cfg_regs_bank.sv
// Register array, address decode, saturating error counter and optional lock.
// Optional lock register is built only when MEM_CFG_LOCK_EN is defined.
module cfg_reg_bank
  import switch_cfg_pkg::*;
#(
  parameter int         NUM_PORTS    = 4,
  parameter logic [7:0] PORT_RST_VAL = 8'h00
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic                   err_inc,
  input  logic [7:0]             addr,
  input  logic [7:0]             wdata,
  output logic [7:0]             rdata,
  output logic                   err,
  output logic [NUM_PORTS*8-1:0] port_addr,
  output logic                   sw_enable
);

  logic [7:0] port_regs [NUM_PORTS];
  logic [7:0] err_cnt;
  logic [7:0] port_off;
  logic       port_hit;
  logic       ctrl_hit;
  logic       err_hit;
  logic       lock_hit;
  logic       locked;

  assign port_off = addr - CFG_PORT_BASE;
  assign port_hit = (port_off < 8'(NUM_PORTS));
  assign ctrl_hit = (addr == CFG_CTRL_ADDR);
  assign err_hit  = (addr == CFG_ERR_ADDR);

`ifdef MEM_CFG_LOCK_EN
  assign lock_hit = (addr == CFG_LOCK_ADDR);

  always_ff @(posedge clk) begin
    if (rst)
      locked <= 1'b0;
    else if (we && lock_hit && (wdata == CFG_LOCK_KEY))
      locked <= 1'b1;
  end
`else
  assign lock_hit = 1'b0;
  assign locked   = 1'b0;
`endif

  // Unmapped accesses, writes to the read-only counter and writes blocked by the lock are errors.
  assign err = ~(port_hit | ctrl_hit | err_hit | lock_hit)
             | (we & err_hit)
             | (we & locked & (port_hit | ctrl_hit));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PORTS; i++)
        port_regs[i] <= PORT_RST_VAL;
      sw_enable <= 1'b0;
    end else if (we && !locked) begin
      for (int i = 0; i < NUM_PORTS; i++)
        if (port_off == 8'(i))
          port_regs[i] <= wdata;
      if (ctrl_hit)
        sw_enable <= wdata[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      err_cnt <= 8'h00;
    else if (err_inc && (err_cnt != 8'hFF))
      err_cnt <= err_cnt + 8'h01;
  end

  always_comb begin
    rdata = 8'h00;
    for (int i = 0; i < NUM_PORTS; i++)
      if (port_off == 8'(i))
        rdata = port_regs[i];
    if (ctrl_hit)
      rdata = {7'b0, sw_enable};
    if (err_hit)
      rdata = err_cnt;
    if (lock_hit)
      rdata = {7'b0, locked};
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    assign port_addr[8*g +: 8] = port_regs[g];
  end

endmodule

// File: rtl/switch_cfg_regs.sv
// Memory-interface responder: request capture and ack handshake around cfg_reg_bank.
// Define MEM_CFG_LOCK_EN to add the write-lock register at 0x11.
module switch_cfg_regs
  import switch_cfg_pkg::*;
#(
  parameter int         NUM_PORTS    = 4,
  parameter logic [7:0] PORT_RST_VAL = 8'h00
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_sel_en,
  input  logic [7:0]             mem_addr,
  input  logic [7:0]             mem_wr_data,
  input  logic                   mem_wr_rd_s,
  output logic [7:0]             mem_rd_data,
  output logic                   mem_ack,
  output logic [NUM_PORTS*8-1:0] port_addr_o,
  output logic                   sw_enable_o
);

  cfg_state_t state;
  logic [7:0] req_addr;
  logic [7:0] req_data;
  logic       req_wr;
  logic [7:0] bank_rdata;
  logic       bank_err;
  logic       exec_now;

  // Writes and error counting commit only in the EXEC cycle, alongside the ack.
  assign exec_now = (state == EXEC);

  cfg_reg_bank #(
    .NUM_PORTS    (NUM_PORTS),
    .PORT_RST_VAL (PORT_RST_VAL)
  ) u_bank (
    .clk       (clk),
    .rst       (rst),
    .we        (exec_now & req_wr),
    .err_inc   (exec_now & bank_err),
    .addr      (req_addr),
    .wdata     (req_data),
    .rdata     (bank_rdata),
    .err       (bank_err),
    .port_addr (port_addr_o),
    .sw_enable (sw_enable_o)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mem_ack     <= 1'b0;
      mem_rd_data <= 8'h00;
      req_addr    <= 8'h00;
      req_data    <= 8'h00;
      req_wr      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mem_ack <= 1'b0;
          if (mem_sel_en) begin
            req_addr <= mem_addr;
            req_data <= mem_wr_data;
            req_wr   <= mem_wr_rd_s;
            state    <= EXEC;
          end
        end
        EXEC: begin
          mem_ack <= 1'b1;
          if (!req_wr)
            mem_rd_data <= bank_rdata;
          state <= WAIT_REL;
        end
        WAIT_REL: begin
          // The master must drop sel_en before another access is accepted.
          mem_ack <= 1'b0;
          if (!mem_sel_en)
            state <= IDLE;
        end
        default: begin
          mem_ack <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_switch_cfg_regs.sv
// Scoreboard bench for switch_cfg_regs; expected read data is queued at issue and checked on ack.
module tb_switch_cfg_regs;

  localparam int NUM_PORTS = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   mem_sel_en;
  logic [7:0]             mem_addr;
  logic [7:0]             mem_wr_data;
  logic                   mem_wr_rd_s;
  logic [7:0]             mem_rd_data;
  logic                   mem_ack;
  logic [NUM_PORTS*8-1:0] port_addr_o;
  logic                   sw_enable_o;

  int checks = 0;
  int errors = 0;

  logic [7:0] sb[$];

  logic [7:0] m_port [NUM_PORTS];
  logic       m_ctrl;
  logic       m_lock;
  logic [7:0] m_err;
  logic [7:0] m_last_rd;

  always #5 clk = ~clk;

  switch_cfg_regs #(
    .NUM_PORTS    (NUM_PORTS),
    .PORT_RST_VAL (8'h00)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_sel_en  (mem_sel_en),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_wr_rd_s (mem_wr_rd_s),
    .mem_rd_data (mem_rd_data),
    .mem_ack     (mem_ack),
    .port_addr_o (port_addr_o),
    .sw_enable_o (sw_enable_o)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NUM_PORTS*8-1:0] modelPorts();
    logic [NUM_PORTS*8-1:0] v;
    for (int i = 0; i < NUM_PORTS; i++)
      v[8*i +: 8] = m_port[i];
    return v;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NUM_PORTS; i++)
      m_port[i] = 8'h00;
    m_ctrl    = 1'b0;
    m_lock    = 1'b0;
    m_err     = 8'h00;
    m_last_rd = 8'h00;
  endtask

  // Every ack pops one expected mem_rd_data value; an ack with nothing queued is spurious.
  always @(negedge clk) begin
    if (!rst && mem_ack) begin
      if (sb.size() == 0)
        checkOutput("spurious_ack", 32'd1, 32'd0);
      else
        checkOutput("rd_data", {24'h0, mem_rd_data}, {24'h0, sb.pop_front()});
    end
  end

  task automatic applyStimulus(input logic [7:0] addr, input logic [7:0] data,
                               input logic wr, input int hold);
    logic       mapped;
    logic       is_port;
    logic       is_err;
    logic       was_locked;
    logic [7:0] rd;
    int         acks;
    int         first;

    was_locked = m_lock;
    is_port    = (addr < 8'(NUM_PORTS));
    mapped     = is_port || (addr == 8'h10) || (addr == 8'h20);
`ifdef MEM_CFG_LOCK_EN
    mapped = mapped || (addr == 8'h11);
`endif
    rd = 8'h00;
    if (is_port) rd = m_port[int'(addr)];
    else if (addr == 8'h10) rd = {7'b0, m_ctrl};
    else if (addr == 8'h20) rd = m_err;
`ifdef MEM_CFG_LOCK_EN
    else if (addr == 8'h11) rd = {7'b0, m_lock};
`endif
    is_err = !mapped || (wr && addr == 8'h20) || (wr && was_locked && (is_port || addr == 8'h10));
    if (wr && !was_locked) begin
      if (is_port) m_port[int'(addr)] = data;
      if (addr == 8'h10) m_ctrl = data[0];
    end
`ifdef MEM_CFG_LOCK_EN
    if (wr && addr == 8'h11 && data == 8'hA5) m_lock = 1'b1;
`endif
    if (is_err && m_err != 8'hFF) m_err = m_err + 8'h01;
    if (!wr) m_last_rd = rd;
    sb.push_back(m_last_rd);

    @(negedge clk);
    mem_sel_en  = 1'b1;
    mem_addr    = addr;
    mem_wr_data = data;
    mem_wr_rd_s = wr;
    acks  = 0;
    first = 0;
    for (int c = 1; c <= hold + 20; c++) begin
      @(negedge clk);
      if (mem_ack) begin
        acks++;
        if (first == 0) first = c;
        if (wr) begin
          checkOutput("port_addr_o", 32'(port_addr_o), 32'(modelPorts()));
          checkOutput("sw_enable_o", {31'h0, sw_enable_o}, {31'h0, m_ctrl});
        end
      end
      if (acks > 0 && c >= hold) break;
    end
    mem_sel_en = 1'b0;
    checkOutput("ack_latency", first, 2);
    checkOutput("ack_count", acks, 1);
    @(negedge clk);
  endtask

  initial begin
    rst         = 1'b1;
    mem_sel_en  = 1'b0;
    mem_addr    = 8'h00;
    mem_wr_data = 8'h00;
    mem_wr_rd_s = 1'b0;
    modelReset();
    repeat (3) @(negedge clk);
    checkOutput("rst_ack", {31'h0, mem_ack}, 32'h0);
    checkOutput("rst_rd_data", {24'h0, mem_rd_data}, 32'h0);
    checkOutput("rst_ports", 32'(port_addr_o), 32'h0);
    checkOutput("rst_sw_enable", {31'h0, sw_enable_o}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] reset-value reads");
    for (int a = 0; a < NUM_PORTS; a++)
      applyStimulus(8'(a), 8'h00, 1'b0, 0);
    applyStimulus(8'h10, 8'h00, 1'b0, 0);
    applyStimulus(8'h20, 8'h00, 1'b0, 0);

    $display("[TB] port write and readback");
    applyStimulus(8'h02, 8'h5C, 1'b1, 0);
    checkOutput("port2_field", {24'h0, port_addr_o[23:16]}, 32'h5C);
    applyStimulus(8'h02, 8'h00, 1'b0, 0);
    applyStimulus(8'h00, 8'hE1, 1'b1, 0);
    applyStimulus(8'h03, 8'h3B, 1'b1, 0);
    applyStimulus(8'h00, 8'h00, 1'b0, 0);

    $display("[TB] long sel_en hold on CTRL write");
    applyStimulus(8'h10, 8'hFF, 1'b1, 10);
    applyStimulus(8'h10, 8'h00, 1'b0, 0);

    $display("[TB] error accesses");
    applyStimulus(8'h33, 8'h00, 1'b0, 0);
    applyStimulus(8'h20, 8'h11, 1'b1, 0);
    applyStimulus(8'h20, 8'h00, 1'b0, 0);
    applyStimulus(8'h33, 8'h44, 1'b1, 0);
    applyStimulus(8'h20, 8'h00, 1'b0, 0);

    $display("[TB] reset during EXEC");
    @(negedge clk);
    mem_sel_en  = 1'b1;
    mem_addr    = 8'h01;
    mem_wr_data = 8'h99;
    mem_wr_rd_s = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    mem_sel_en = 1'b0;
    rst        = 1'b0;
    modelReset();
    checkOutput("exec_rst_ack", {31'h0, mem_ack}, 32'h0);
    checkOutput("exec_rst_ports", 32'(port_addr_o), 32'h0);
    checkOutput("exec_rst_sw_enable", {31'h0, sw_enable_o}, 32'h0);
    checkOutput("exec_rst_rd_data", {24'h0, mem_rd_data}, 32'h0);
    repeat (3) @(negedge clk);
    applyStimulus(8'h01, 8'h00, 1'b0, 0);
    applyStimulus(8'h20, 8'h00, 1'b0, 0);
    applyStimulus(8'h01, 8'h42, 1'b1, 0);
    applyStimulus(8'h01, 8'h00, 1'b0, 0);

    $display("[TB] lock register");
    applyStimulus(8'h11, 8'h3C, 1'b1, 0);
    applyStimulus(8'h11, 8'h00, 1'b0, 0);
    applyStimulus(8'h11, 8'hA5, 1'b1, 0);
    applyStimulus(8'h00, 8'h77, 1'b1, 0);
    applyStimulus(8'h10, 8'h01, 1'b1, 0);
    applyStimulus(8'h00, 8'h00, 1'b0, 0);
    applyStimulus(8'h20, 8'h00, 1'b0, 0);
    applyStimulus(8'h11, 8'h00, 1'b0, 0);

    $display("[TB] error counter saturation");
    for (int n = 0; n < 300; n++)
      applyStimulus(8'h40 + 8'(n % 4), 8'h00, 1'(n % 2), 0);
    applyStimulus(8'h20, 8'h00, 1'b0, 0);
    applyStimulus(8'h01, 8'h00, 1'b0, 0);

    repeat (4) @(negedge clk);
    checkOutput("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
